// File: rtl/eisenberg_grant_sched_pkg.sv
// Shared types for the Eisenberg-McGuire scheduler and its model: requester activity,
// scheduler state and the modulo ring increment used to walk requester indices.
package eisenberg_grant_sched_pkg;

   typedef enum logic [1:0] {idle, waiting, active} activity_t;

   typedef enum logic [1:0] {IDLE, SCAN, GRANT, HAND} sched_state_t;

   function automatic int ring_inc(input int x, input int hiproc);
      return (x == hiproc) ? 0 : x + 1;
   endfunction

endpackage

// File: rtl/eisenberg_grant_sched_if.sv
// Requester-side bundle of the scheduler: level requests, release pulses, grant and status.
// The scheduler sits on the slave modport; the requester pool drives the master modport.
interface eisenberg_grant_sched_if #(
   parameter int HIPROC = 2,
   parameter int SELMSB = 1
);
   logic [HIPROC:0] req;
   logic [HIPROC:0] rel;
   logic [HIPROC:0] gnt;
   logic [SELMSB:0] turn;
   logic            busy;
   logic            overrun;

   modport master (output req, rel, input gnt, turn, busy, overrun);
   modport slave  (input req, rel, output gnt, turn, busy, overrun);
endinterface

// File: rtl/eisenberg_ring_inc.sv
// Combinational modulo-(HIPROC+1) increment of a requester index, zero latency.
// Pure function of its input; no flow control.
module eisenberg_ring_inc
   import eisenberg_grant_sched_pkg::*;
#(
   parameter int HIPROC = 2,
   parameter int SELMSB = 1
) (
   input  logic [SELMSB:0] x,
   output logic [SELMSB:0] y
);
   typedef logic [SELMSB:0] sel_t;

   assign y = sel_t'(ring_inc(int'(x), HIPROC));
endmodule

// File: rtl/eisenberg_grant_sched.sv
// Eisenberg-McGuire turn scheduler: one-hot grant 2+d edges after an idle request, d+1 after a release.
// No backpressure: req is a level, rel a pulse honoured only from the current grantee.
module eisenberg_grant_sched
   import eisenberg_grant_sched_pkg::*;
#(
   parameter int HIPROC  = 2,
   parameter int SELMSB  = 1,
   parameter int HOLDMSB = 3,
   parameter int MAXHOLD = 12
) (
   input logic                    clock,
   input logic                    reset,
   eisenberg_grant_sched_if.slave bus
);
   localparam int N = HIPROC + 1;

   typedef logic [SELMSB:0]  sel_t;
   typedef logic [HIPROC:0]  vec_t;
   typedef logic [HOLDMSB:0] hold_t;

   localparam sel_t  SCAN_LAST = sel_t'(HIPROC);
   localparam sel_t  HAND_LAST = sel_t'(HIPROC - 1);
   localparam hold_t HOLD_LIM  = hold_t'(MAXHOLD);

   activity_t    flag_q [N];
   activity_t    flag_d [N];
   sched_state_t state_q, state_d;
   sel_t         turn_q, turn_d;
   sel_t         j_q, j_d;
   sel_t         cnt_q, cnt_d;
   hold_t        hold_q, hold_d;
   vec_t         gnt_q, gnt_d;
   logic         ovr_q, ovr_d;

   logic         any_waiting;
   logic         j_waiting;
   logic         rel_hit;
   sel_t         inc_in, inc_out;

   always_comb begin
      any_waiting = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (flag_q[i] == waiting) any_waiting = 1'b1;
      end
   end

   assign j_waiting = (flag_q[j_q] == waiting);
   assign rel_hit   = bus.rel[turn_q];
   assign inc_in    = (state_q == GRANT) ? turn_q : j_q;

   eisenberg_ring_inc #(
      .HIPROC (HIPROC),
      .SELMSB (SELMSB)
   ) u_inc (
      .x (inc_in),
      .y (inc_out)
   );

   always_comb begin
      state_d = state_q;
      turn_d  = turn_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      ovr_d   = ovr_q;

      // Free-running request tracking; the FSM below overrides the entering/leaving holder.
      for (int i = 0; i < N; i++) begin
         flag_d[i] = flag_q[i];
         case (flag_q[i])
            idle:    if (bus.req[i])  flag_d[i] = waiting;
            waiting: if (!bus.req[i]) flag_d[i] = idle;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (any_waiting) begin
               state_d = SCAN;
               j_d     = turn_q;
               cnt_d   = '0;
            end
         end
         SCAN: begin
            if (j_waiting) begin
               flag_d[j_q] = active;
               turn_d      = j_q;
               gnt_d       = vec_t'(1) << j_q;
               hold_d      = '0;
               state_d     = GRANT;
            end else begin
               j_d   = inc_out;
               cnt_d = cnt_q + sel_t'(1);
               if (cnt_q == SCAN_LAST) state_d = IDLE;
            end
         end
         GRANT: begin
            if (rel_hit) begin
               flag_d[turn_q] = idle;
               gnt_d          = '0;
               j_d            = inc_out;
               cnt_d          = '0;
               state_d        = HAND;
            end else begin
               if (hold_q != '1)       hold_d = hold_q + hold_t'(1);
               if (hold_q >= HOLD_LIM) ovr_d  = 1'b1;
            end
         end
         HAND: begin
            // The releaser itself is never probed here; it is reached again via IDLE.
            if (j_waiting) begin
               turn_d  = j_q;
               state_d = SCAN;
            end else begin
               j_d   = inc_out;
               cnt_d = cnt_q + sel_t'(1);
               if (cnt_q == HAND_LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         turn_q  <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < N; i++) flag_q[i] <= idle;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         ovr_q   <= ovr_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.turn    = turn_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_eisenberg_grant_sched.sv
// Bench for eisenberg_grant_sched (HIPROC=2, MAXHOLD=12): per-cycle vector table, corner sequences,
// then randomized rounds checked against a distance-based grant-order/latency model.
module tb_eisenberg_grant_sched;

   logic clock;
   logic reset;

   eisenberg_grant_sched_if #(.HIPROC(2), .SELMSB(1)) bus ();

   eisenberg_grant_sched #(
      .HIPROC  (2),
      .SELMSB  (1),
      .HOLDMSB (3),
      .MAXHOLD (12)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       rst;
      logic [2:0] req;
      logic [2:0] rel;
      logic [2:0] gnt;
      logic [1:0] turn;
      logic       busy;
      logic       ovr;
   } tv_t;

   tv_t tbl[$];
   int  tests = 0;
   int  fails = 0;

   int         turn_m, g, g2, d, lat, hold_n;
   logic [2:0] r;
   bit         granted;

   function automatic tv_t row(input logic rst, input logic [2:0] req, input logic [2:0] rel,
                               input logic [2:0] gnt, input logic [1:0] turn,
                               input logic busy, input logic ovr);
      tv_t t;
      t.rst = rst; t.req = req; t.rel = rel; t.gnt = gnt;
      t.turn = turn; t.busy = busy; t.ovr = ovr;
      return t;
   endfunction

   function automatic logic [2:0] onehot(input int i);
      logic [2:0] one;
      one = 3'b001;
      return one << i;
   endfunction

   // Distance from 'from' to the first requester in m, searching distances dmin..2.
   function automatic int first_dist(input logic [2:0] m, input int from, input int dmin);
      for (int k = dmin; k <= 2; k++) begin
         if (m[(from + k) % 3]) return k;
      end
      return -1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      bus.req = '0;
      bus.rel = '0;

      // reset, single requester, release to idle
      tbl.push_back(row(1, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 0, 0, 0));
      tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b010, 3'b000, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b010, 3'b000, 3'b010, 1, 1, 0));
      tbl.push_back(row(0, 3'b000, 3'b010, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      // all three requesting, rotation 0,1,2,0
      tbl.push_back(row(1, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b001, 0, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b001, 0, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b001, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b010, 1, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b010, 1, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b010, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 2, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b100, 2, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b100, 2, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b100, 3'b000, 2, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b111, 3'b000, 3'b001, 0, 1, 0));
      // foreign release ignored, then handoff 0->1 and 1->0
      tbl.push_back(row(0, 3'b011, 3'b100, 3'b001, 0, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b001, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b000, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b000, 3'b010, 1, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b010, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b000, 3'b000, 1, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b000, 3'b000, 0, 1, 0));
      tbl.push_back(row(0, 3'b011, 3'b000, 3'b001, 0, 1, 0));

      foreach (tbl[i]) begin
         reset   = tbl[i].rst;
         bus.req = tbl[i].req;
         bus.rel = tbl[i].rel;
         step();
         check($sformatf("vec%0d_gnt", i),  int'(bus.gnt),     int'(tbl[i].gnt));
         check($sformatf("vec%0d_turn", i), int'(bus.turn),    int'(tbl[i].turn));
         check($sformatf("vec%0d_busy", i), int'(bus.busy),    int'(tbl[i].busy));
         check($sformatf("vec%0d_ovr", i),  int'(bus.overrun), int'(tbl[i].ovr));
      end

      // overrun: 13 held cycles set it, only reset clears it
      reset = 1'b1; bus.req = '0; bus.rel = '0; step(); reset = 1'b0;
      bus.req = 3'b001;
      repeat (2) step();
      check("ovr_pre_gnt", int'(bus.gnt), 0);
      step();
      check("ovr_gnt", int'(bus.gnt), 1);
      for (int k = 0; k < 12; k++) begin
         step();
         check("ovr_early", int'(bus.overrun), 0);
      end
      step();
      check("ovr_set", int'(bus.overrun), 1);
      bus.req = 3'b000; bus.rel = 3'b001; step(); bus.rel = '0;
      check("ovr_rel_gnt", int'(bus.gnt), 0);
      check("ovr_sticky_rel", int'(bus.overrun), 1);
      repeat (3) step();
      check("ovr_sticky_idle", int'(bus.overrun), 1);
      reset = 1'b1; step(); reset = 1'b0;
      check("ovr_reset", int'(bus.overrun), 0);

      // withdrawn request: HAND finds nobody and returns to IDLE
      bus.req = 3'b001;
      repeat (3) step();
      check("wd_gnt", int'(bus.gnt), 1);
      bus.req = 3'b101; step();
      bus.req = 3'b001; step();
      bus.req = 3'b000; bus.rel = 3'b001; step(); bus.rel = '0;
      check("wd_rel_gnt", int'(bus.gnt), 0);
      step();
      check("wd_hand_busy", int'(bus.busy), 1);
      step();
      check("wd_idle_busy", int'(bus.busy), 0);
      check("wd_idle_gnt", int'(bus.gnt), 0);
      check("wd_idle_turn", int'(bus.turn), 0);
      step();
      check("wd_stay_gnt", int'(bus.gnt), 0);
      check("wd_stay_busy", int'(bus.busy), 0);

      // reset mid-grant drops the grant and restarts from turn 0
      reset = 1'b1; step(); reset = 1'b0;
      bus.req = 3'b100;
      repeat (4) step();
      check("rs_pre_gnt", int'(bus.gnt), 0);
      step();
      check("rs_gnt", int'(bus.gnt), 4);
      check("rs_turn", int'(bus.turn), 2);
      reset = 1'b1; bus.req = 3'b001; step();
      check("rs_drop_gnt", int'(bus.gnt), 0);
      check("rs_drop_busy", int'(bus.busy), 0);
      check("rs_drop_turn", int'(bus.turn), 0);
      reset = 1'b0;
      step();
      check("rs_e0_gnt", int'(bus.gnt), 0);
      step();
      check("rs_e1_gnt", int'(bus.gnt), 0);
      check("rs_e1_busy", int'(bus.busy), 1);
      step();
      check("rs_regnt", int'(bus.gnt), 1);
      check("rs_regnt_turn", int'(bus.turn), 0);

      // randomized rounds against the rotation/latency model
      reset = 1'b1; bus.req = '0; bus.rel = '0; step(); reset = 1'b0;
      turn_m  = 0;
      granted = 1'b0;
      g       = 0;
      for (int round = 0; round < 200; round++) begin
         if (!granted) begin
            r       = 3'($urandom_range(1, 7));
            bus.req = r;
            d       = first_dist(r, turn_m, 0);
            g       = (turn_m + d) % 3;
            for (int k = 0; k < 2 + d; k++) begin
               step();
               check("rnd_idle_wait", int'(bus.gnt), 0);
            end
            step();
            check("rnd_idle_gnt", int'(bus.gnt), int'(onehot(g)));
            check("rnd_idle_turn", int'(bus.turn), g);
            turn_m  = g;
            granted = 1'b1;
         end

         hold_n = $urandom_range(1, 6);
         for (int k = 0; k < hold_n; k++) begin
            bus.req = 3'($urandom);
            bus.rel = 3'($urandom) & ~onehot(g);
            step();
            check("rnd_hold_gnt", int'(bus.gnt), int'(onehot(g)));
         end

         r       = 3'($urandom);
         bus.req = r;
         bus.rel = onehot(g) | (3'($urandom) & ~onehot(g));
         step();
         bus.rel = '0;
         check("rnd_rel_gnt", int'(bus.gnt), 0);

         d = first_dist(r, g, 1);
         if (d > 0) begin
            lat = d + 1;
            g2  = (g + d) % 3;
         end else if (r[g]) begin
            lat = 4;
            g2  = g;
         end else begin
            lat = 0;
            g2  = g;
         end

         if (lat > 0) begin
            for (int k = 0; k < lat - 1; k++) begin
               step();
               check("rnd_hand_wait", int'(bus.gnt), 0);
            end
            step();
            check("rnd_hand_gnt", int'(bus.gnt), int'(onehot(g2)));
            check("rnd_hand_turn", int'(bus.turn), g2);
            g       = g2;
            turn_m  = g2;
            granted = 1'b1;
         end else begin
            repeat (2) step();
            check("rnd_idle_busy", int'(bus.busy), 0);
            check("rnd_idle_zero", int'(bus.gnt), 0);
            check("rnd_idle_keep", int'(bus.turn), turn_m);
            granted = 1'b0;
         end
      end
      check("rnd_no_overrun", int'(bus.overrun), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
